brent_kung_subtractor_pipe: RTL and testbench



---
 rtl/brent_kung_subtractor_pipe_if.sv | 28 ++
 rtl/brent_kung_subtractor_pipe.sv | 168 ++++++++++++++++
 tb/tb_brent_kung_subtractor_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/brent_kung_subtractor_pipe_if.sv
// Operand/result handshake bundle for brent_kung_subtractor_pipe.
// master = producer/consumer side (testbench or ALU), slave = subtractor.
interface brent_kung_subtractor_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, inA, inB, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, inA, inB, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, neg, ovf
    );
endinterface

// File: rtl/brent_kung_subtractor_pipe.sv
// Two-stage pipelined A - B - bin subtractor on a Brent-Kung prefix network.
// Stage 1 resolves the low WIDTH/2 bits and the mid carry, stage 2 (the output
// register) resolves the high half, borrow-out and flags.
// Optional: define SUB_FLAGS_EN to build the zero/neg/ovf flags; otherwise
// they are tied to 0.
module brent_kung_subtractor_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    brent_kung_subtractor_pipe_if.slave   bus
);
    localparam int unsigned HW   = WIDTH / 2;
    localparam int unsigned LOGH = $clog2(HW);
    localparam int unsigned IDXW = (LOGH == 0) ? 1 : LOGH;

    // Brent-Kung carries for an HW-bit slice: c[0] = cin, c[i+1] = carry out of bit i.
    function automatic logic [HW:0] bk_carry(input logic [HW-1:0] g_in,
                                             input logic [HW-1:0] p_in,
                                             input logic          cin);
        logic [HW-1:0] gg;
        logic [HW-1:0] pp;
        logic [HW:0]   c;
        gg    = g_in;
        pp    = p_in;
        gg[0] = g_in[0] | (p_in[0] & cin);
        // up-sweep: build group terms at positions 2d-1, 4d-1, ...
        for (int d = 1; d < int'(HW); d = d * 2) begin
            for (int i = 2 * d - 1; i < int'(HW); i = i + 2 * d) begin
                gg[IDXW'(i)] = gg[IDXW'(i)] | (pp[IDXW'(i)] & gg[IDXW'(i - d)]);
                pp[IDXW'(i)] = pp[IDXW'(i)] & pp[IDXW'(i - d)];
            end
        end
        // down-sweep: fill in the remaining prefixes from the resolved ones
        for (int lvl = int'(LOGH); lvl >= 0; lvl--) begin
            for (int i = 3 * (1 << lvl) - 1; i < int'(HW); i = i + 2 * (1 << lvl)) begin
                gg[IDXW'(i)] = gg[IDXW'(i)] | (pp[IDXW'(i)] & gg[IDXW'(i - (1 << lvl))]);
                pp[IDXW'(i)] = pp[IDXW'(i)] & pp[IDXW'(i - (1 << lvl))];
            end
        end
        c[0]    = cin;
        c[HW:1] = gg;
        return c;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic          out_valid_q, out_valid_d;
    logic          s2_load;
    logic          in_ready_c;
    logic          accept;

    logic [HW-1:0] s1_diff_lo_q, s1_diff_lo_d;
    logic          s1_c_mid_q, s1_c_mid_d;
    logic [HW-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HW-1:0] s1_nb_hi_q, s1_nb_hi_d;

    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    // Handshake: S2 drains when empty or consumer takes the beat; S1 refills behind it.
    always_comb begin
        s2_load     = s1_valid_q & (~out_valid_q | bus.out_ready);
        in_ready_c  = ~s1_valid_q | s2_load;
        accept      = bus.in_valid & in_ready_c;
        s1_valid_d  = accept | (s1_valid_q & ~s2_load);
        out_valid_d = s2_load | (out_valid_q & ~bus.out_ready);
    end

    // Stage 1 datapath: low-half difference and carry into the high half.
    always_comb begin
        logic [HW-1:0] a_lo;
        logic [HW-1:0] nb_lo;
        logic [HW:0]   c_lo;
        a_lo         = bus.inA[HW-1:0];
        nb_lo        = ~bus.inB[HW-1:0];
        c_lo         = bk_carry(a_lo & nb_lo, a_lo ^ nb_lo, ~bus.bin);
        s1_diff_lo_d = (a_lo ^ nb_lo) ^ c_lo[HW-1:0];
        s1_c_mid_d   = c_lo[HW];
        s1_a_hi_d    = bus.inA[WIDTH-1:HW];
        s1_nb_hi_d   = ~bus.inB[WIDTH-1:HW];
    end

    // Stage 2 datapath: high-half difference with carry-in from stage 1.
    always_comb begin
        logic [HW:0] c_hi;
        c_hi   = bk_carry(s1_a_hi_q & s1_nb_hi_q, s1_a_hi_q ^ s1_nb_hi_q, s1_c_mid_q);
        diff_d = {(s1_a_hi_q ^ s1_nb_hi_q) ^ c_hi[HW-1:0], s1_diff_lo_q};
        bout_d = ~c_hi[HW];
    end

    // Valid bits for both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1 data registers, loaded on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff_lo_q <= '0;
            s1_c_mid_q   <= 1'b0;
            s1_a_hi_q    <= '0;
            s1_nb_hi_q   <= '0;
        end else if (accept) begin
            s1_diff_lo_q <= s1_diff_lo_d;
            s1_c_mid_q   <= s1_c_mid_d;
            s1_a_hi_q    <= s1_a_hi_d;
            s1_nb_hi_q   <= s1_nb_hi_d;
        end
    end

    // Output register, loaded when stage 1 moves into stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (s2_load) begin
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

`ifdef SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic ovf_q, ovf_d;

    // Flags from the stage-2 result; B's msb is the inverse of the stored ~B msb.
    always_comb begin
        zero_d = (diff_d == '0);
        neg_d  = diff_d[WIDTH-1];
        ovf_d  = (s1_a_hi_q[HW-1] != ~s1_nb_hi_q[HW-1]) &
                 (diff_d[WIDTH-1] != s1_a_hi_q[HW-1]);
    end

    // Flag registers share the output-register enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (s2_load) begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
    assign bus.ovf  = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_brent_kung_subtractor_pipe.sv
// Self-checking bench for brent_kung_subtractor_pipe: directed corner vectors,
// backpressure, mid-flight reset and a randomized stream against a plain
// arithmetic reference model. Results are packed {diff, bout, zero, neg, ovf}.
module tb_brent_kung_subtractor_pipe;
    localparam int unsigned W = 32;
`ifdef SUB_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    brent_kung_subtractor_pipe_if #(.WIDTH(W)) bus ();

    brent_kung_subtractor_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  n_cmp;
    int unsigned  n_err;
    logic [35:0]  exp_q[$];
    logic         hold_pending;
    logic [35:0]  held;
    logic         last_acc;

    function automatic logic [35:0] outv();
        return {bus.diff, bus.bout, bus.zero, bus.neg, bus.ovf};
    endfunction

    // Reference: 33-bit unsigned difference and 64-bit signed difference.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic bi);
        logic [32:0] wide;
        longint      sd;
        logic [31:0] d;
        logic        bo;
        logic        o;
        wide = {1'b0, a} - {1'b0, b} - 33'(bi);
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        d    = wide[31:0];
        bo   = ({1'b0, a} < ({1'b0, b} + 33'(bi)));
        o    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {d, bo, FLAGS_ON & (d == 32'd0), FLAGS_ON & d[31], FLAGS_ON & o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive at negedge, sample settled outputs/handshake before the next posedge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic bi, input logic ordy,
                        input bit has_exp = 1'b0, input logic [35:0] exp_v = '0);
        logic [35:0] e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.inA       = a;
        bus.inB       = b;
        bus.bin       = bi;
        bus.out_ready = ordy;
        #1;
        if (hold_pending) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(outv()), 64'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(outv()), 64'(e));
            end
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        held         = outv();
        last_acc     = v && bus.in_ready;
        if (last_acc) begin
            if (has_exp)
                exp_q.push_back(exp_v & {32'hFFFF_FFFF, 1'b1, {3{FLAGS_ON}}});
            else
                exp_q.push_back(model(a, b, bi));
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() > 0; k++)
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned sent;
        int unsigned cycles;
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp         = 0;
        n_err         = 0;
        hold_pending  = 1'b0;
        held          = '0;
        last_acc      = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inA       = '0;
        bus.inB       = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 64'(outv()), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic subtract and two-cycle latency
        step(1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 1'b1, {32'd2, 4'b0000});
        chk("basic_acc", 64'(last_acc), 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("lat_not_yet", 64'(bus.out_valid), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);

        // borrow/wrap and cross-half/overflow corners, back-to-back
        step(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, {32'hFFFF_FFFF, 4'b1010});
        step(1'b1, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 1'b1, {32'h0000_0000, 4'b0100});
        chk("tput_acc1", 64'(last_acc), 64'd1);
        step(1'b1, 32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 1'b1, {32'hFFFF_FFFF, 4'b1010});
        chk("tput_acc2", 64'(last_acc), 64'd1);
        step(1'b1, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, {32'h0000_FFFF, 4'b0000});
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, {32'h7FFF_FFFF, 4'b0001});
        step(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, {32'h8000_0000, 4'b1011});
        chk("tput_acc3", 64'(last_acc), 64'd1);
        drain("drain_directed");

        // backpressure: capacity 2, hold 9, then 9/18/27 on consecutive cycles
        step(1'b1, 32'd10, 32'd1, 1'b0, 1'b0);
        chk("bp_acc1", 64'(last_acc), 64'd1);
        step(1'b1, 32'd20, 32'd2, 1'b0, 1'b0);
        chk("bp_acc2", 64'(last_acc), 64'd1);
        step(1'b1, 32'd30, 32'd3, 1'b0, 1'b0);
        chk("bp_full", 64'(bus.in_ready), 64'd0);
        chk("bp_head", 64'(bus.diff), 64'd9);
        step(1'b1, 32'd30, 32'd3, 1'b0, 1'b0);
        chk("bp_full2", 64'(bus.in_ready), 64'd0);
        step(1'b1, 32'd30, 32'd3, 1'b0, 1'b1);
        chk("bp_acc3", 64'(last_acc), 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("bp_out18", 64'(bus.diff), 64'd18);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("bp_out27", 64'(bus.diff), 64'd27);
        drain("drain_bp");

        // reset with two beats in flight
        step(1'b1, 32'd100, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'd200, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("mid_rst_out", 64'(outv()), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
            chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        end

        // randomized stream with random stalls
        sent   = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            ra = rnd32();
            rb = (($urandom % 8) == 0) ? ra : rnd32();
            step(1'(($urandom % 4) != 0), ra, rb, 1'($urandom % 2), 1'(($urandom % 4) != 0));
            if (last_acc) sent++;
            cycles++;
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
